cell_state_maq_pipe: RTL

Pipelined, multi-lane successor to the combinational cell-state multiply-add-quantize stage of the LSTM datapath. It computes the quantized next cell state C_t = f·C_{t-1} + i·g for LANES elements per beat, entirely in the integer (zero-point/scale) domain, with saturation to the state range. Operands arrive from the gate activation quantizers (sigmoid/tanh LUT outputs) and the state buffer; the result feeds the state buffer and the tanh(C_t) path. Every stage is valid/ready-handshaked, and the block also provides selectable rounding, a sequence-start mode and a saturation event counter.

---
 rtl/lstm_q_pkg.sv | 45 ++++
 rtl/maq_lane.sv | 81 ++++++++
 rtl/cell_state_maq_pipe.sv | 95 +++++++++
 3 files changed

// File: rtl/lstm_q_pkg.sv
// Quantization constants, rounding modes and the integer R(n,d) helper shared by the LSTM quantized stages.
package lstm_q_pkg;

  localparam int Q_SCALE_DATA  = 128;
  localparam int Q_ZERO_DATA   = 128;
  localparam int Q_SCALE_STATE = 128;
  localparam int Q_ZERO_STATE  = 128;
  localparam int Q_SCALE_W     = 64;
  localparam int Q_ZERO_W      = 128;
  localparam int Q_SCALE_B     = 8192;
  localparam int Q_ZERO_B      = 0;
  localparam int Q_SCALE_SIG   = 256;
  localparam int Q_ZERO_SIG    = 0;
  localparam int Q_SCALE_TANH  = 128;
  localparam int Q_ZERO_TANH   = 128;

  typedef enum logic {
    RND_TRUNC     = 1'b0,
    RND_HALF_AWAY = 1'b1
  } round_mode_e;

  // Every intermediate (products, scaled terms, sum) lives in one signed 32-bit domain.
  localparam int ACC_W = 32;
  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic bit is_pow2(input int d);
    return (d > 0) && ((d & (d - 1)) == 0);
  endfunction

  // Sign-magnitude division so truncation and half-away rounding are symmetric about zero.
  function automatic acc_t r_div(input acc_t n, input int d, input round_mode_e mode);
    acc_t a;
    acc_t q;
    int   k;
    a = (n < 0) ? -n : n;
    k = $clog2(d);
    if (is_pow2(d)) begin
      q = (mode == RND_HALF_AWAY) ? ((a + acc_t'(d >>> 1)) >>> k) : (a >>> k);
    end else begin
      q = (mode == RND_HALF_AWAY) ? ((a + acc_t'(d >>> 1)) / acc_t'(d)) : (a / acc_t'(d));
    end
    return (n < 0) ? -q : q;
  endfunction

endpackage

// File: rtl/maq_lane.sv
// One lane of C_t = f*C_{t-1} + i*g: S1 products, S2 scale/round, S3 sum/saturate.
// Latency 3 register stages; load enables come from the shared controller, data holds when not loaded.
// No handshake of its own: backpressure is applied by withholding ld1..ld3.
module maq_lane import lstm_q_pkg::*; #(
  parameter int DW          = 8,
  parameter int SCALE_STATE = Q_SCALE_STATE,
  parameter int ZERO_STATE  = Q_ZERO_STATE,
  parameter int SCALE_SIG   = Q_SCALE_SIG,
  parameter int ZERO_SIG    = Q_ZERO_SIG,
  parameter int SCALE_TANH  = Q_SCALE_TANH,
  parameter int ZERO_TANH   = Q_ZERO_TANH,
  parameter int ROUND       = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ld1,
  input  logic          ld2,
  input  logic          ld3,
  input  logic          start,
  input  logic [DW-1:0] f,
  input  logic [DW-1:0] i,
  input  logic [DW-1:0] g,
  input  logic [DW-1:0] c,
  output logic [DW-1:0] out_c,
  output logic          out_sat
);

  localparam round_mode_e RMODE = (ROUND != 0) ? RND_HALF_AWAY : RND_TRUNC;
  localparam acc_t        MAXV  = acc_t'((1 << DW) - 1);

  acc_t df, di, dc, dg;
  acc_t pf_q, pi_q, ctf_q, ig_q;
  acc_t u;
  logic [DW-1:0] res;
  logic          clip;

  always_comb begin
    df = acc_t'(f) - acc_t'(ZERO_SIG);
    di = acc_t'(i) - acc_t'(ZERO_SIG);
    dg = acc_t'(g) - acc_t'(ZERO_TANH);
    dc = start ? '0 : (acc_t'(c) - acc_t'(ZERO_STATE));
  end

  always_comb begin
    u    = ctf_q + ig_q + acc_t'(ZERO_STATE);
    res  = u[DW-1:0];
    clip = 1'b0;
    if (u < 0) begin
      res  = '0;
      clip = 1'b1;
    end else if (u > MAXV) begin
      res  = '1;
      clip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pf_q    <= '0;
      pi_q    <= '0;
      ctf_q   <= '0;
      ig_q    <= '0;
      out_c   <= '0;
      out_sat <= 1'b0;
    end else begin
      if (ld1) begin
        pf_q <= df * dc;
        pi_q <= di * dg * acc_t'(SCALE_STATE);
      end
      if (ld2) begin
        ctf_q <= r_div(pf_q, SCALE_SIG, RMODE);
        ig_q  <= r_div(pi_q, SCALE_SIG * SCALE_TANH, RMODE);
      end
      if (ld3) begin
        out_c   <= res;
        out_sat <= clip;
      end
    end
  end

endmodule

// File: rtl/cell_state_maq_pipe.sv
// Multi-lane pipelined quantized cell-state update with saturation counter.
// Latency 3 cycles, 1 beat/cycle; up to 3 beats buffered in S1..S3.
// Valid/ready per stage: a stage loads when empty or when its successor advances; out_* hold while stalled.
module cell_state_maq_pipe import lstm_q_pkg::*; #(
  parameter int LANES       = 4,
  parameter int DW          = 8,
  parameter int SCALE_STATE = Q_SCALE_STATE,
  parameter int ZERO_STATE  = Q_ZERO_STATE,
  parameter int SCALE_SIG   = Q_SCALE_SIG,
  parameter int ZERO_SIG    = Q_ZERO_SIG,
  parameter int SCALE_TANH  = Q_SCALE_TANH,
  parameter int ZERO_TANH   = Q_ZERO_TANH,
  parameter int ROUND       = 0,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_start,
  input  logic [LANES*DW-1:0] in_f,
  input  logic [LANES*DW-1:0] in_i,
  input  logic [LANES*DW-1:0] in_g,
  input  logic [LANES*DW-1:0] in_c,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] out_c,
  output logic [LANES-1:0]    out_sat,
  output logic [CNT_W-1:0]    sat_cnt,
  input  logic                sat_clr
);

  localparam int PW = $clog2(LANES + 1);

  logic v1, v2, v3;
  logic en1, en2, en3;
  logic ld1, ld2, ld3;

  assign en3       = !v3 || out_ready;
  assign en2       = !v2 || en3;
  assign en1       = !v1 || en2;
  assign ld1       = en1 && in_valid;
  assign ld2       = en2 && v1;
  assign ld3       = en3 && v2;
  assign in_ready  = en1;
  assign out_valid = v3;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    maq_lane #(
      .DW(DW), .SCALE_STATE(SCALE_STATE), .ZERO_STATE(ZERO_STATE),
      .SCALE_SIG(SCALE_SIG), .ZERO_SIG(ZERO_SIG),
      .SCALE_TANH(SCALE_TANH), .ZERO_TANH(ZERO_TANH), .ROUND(ROUND)
    ) u_lane (
      .clk(clk), .rstn(rstn),
      .ld1(ld1), .ld2(ld2), .ld3(ld3),
      .start(in_start),
      .f(in_f[l*DW +: DW]), .i(in_i[l*DW +: DW]),
      .g(in_g[l*DW +: DW]), .c(in_c[l*DW +: DW]),
      .out_c(out_c[l*DW +: DW]), .out_sat(out_sat[l])
    );
  end

  logic [PW-1:0]  pop;
  logic [CNT_W:0] sum;

  always_comb begin
    pop = '0;
    for (int l = 0; l < LANES; l++) pop = pop + PW'(out_sat[l]);
    sum = {1'b0, sat_cnt} + (CNT_W+1)'(pop);
  end

  // Clear wins over a same-cycle increment; a carry out pins the count at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      sat_cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

endmodule
